uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte-stream requesters. Each requester presents bytes on a valid/ready handshake. The arbiter picks a winner, hands its byte to the transmitter with a one-cycle start pulse, and tracks the transmitter's busy flag until the frame completes. Multi-byte messages are kept contiguous with a per-byte `last` flag. A watchdog recovers if the transmitter never acknowledges a start.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters (2..8).
- `START_TIMEOUT`, default 16: clk cycles to wait for `tx_busy` rise after `tx_start`.

Ports:
- `clk`, input, 1: single system clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-low; `reset=0` forces all state to reset values.
- `req_valid`, input, `NUM_REQ`: requester i has a byte pending.
- `req_data`, input, `8*NUM_REQ`: byte of requester i in bits [8i+7:8i].
- `req_last`, input, `NUM_REQ`: byte of requester i ends its message.
- `req_ready`, output, `NUM_REQ`: one-hot, one-cycle accept pulse.
- `tx_start`, output, 1: one-cycle pulse requesting a frame.
- `tx_data`, output, 8: byte for the transmitter; held stable from `tx_start` to frame end.
- `tx_busy`, input, 1: transmitter frame in progress.
- `grant_id`, output, `$clog2(NUM_REQ)`: index of the current or last owner.
- `locked`, output, 1: a message is in progress (last byte not yet sent).
- `timeout_err`, output, 1: sticky; set on watchdog expiry, cleared only by reset.

## Operation
- States: `IDLE`, `ISSUE`, `WAIT_BUSY`, `WAIT_DONE`.
- `IDLE`:
  - Not `locked`: the candidate set is all `req_valid`. Search starts at `(ptr+1) mod NUM_REQ`; the first set bit wins.
  - `locked`: only `grant_id` is a candidate; other requesters are ignored.
  - If a winner exists: register the winner's byte into `tx_data`, set `grant_id`, pulse its `req_ready`, and go to `ISSUE`.
- `ISSUE`: pulse `tx_start`, clear the watchdog counter, go to `WAIT_BUSY`.
- `WAIT_BUSY`:
  - `tx_busy=1` moves to `WAIT_DONE`.
  - The counter increments each cycle. At `START_TIMEOUT-1` it sets `timeout_err`, clears `locked`, and returns to `IDLE`. The byte is dropped, not retried.
- `WAIT_DONE`:
  - `tx_busy=0` moves to `IDLE`.
  - Update `ptr<=grant_id`.
  - `locked<=~last_q`, where `last_q` is `req_last` captured with the byte.
- Fairness: `ptr` advances only on completed frames, so after an unlocked message the priority rotates past the winner.
- A locked requester that drops `req_valid` stalls the arbiter in `IDLE`. This is intended: messages are never interleaved.
- Reset values: state `IDLE`, `ptr=NUM_REQ-1` (so requester 0 has first priority), `req_ready=0`, `tx_start=0`, `tx_data=0`, `grant_id=0`, `locked=0`, `timeout_err=0`, counter 0.
- Reset mid-frame: everything returns to reset values immediately. `tx_busy` is ignored until the next `IDLE` grant, and the in-flight byte is abandoned.

## Timing
- Accept to start: `req_ready` is high in cycle T (the `IDLE` decision edge) and `tx_start` in cycle T+1.
- Requester handshake: the byte is consumed on the edge where `req_ready=1`. The requester may change `req_data`/`req_valid` from the next cycle.
- Minimum turnaround: from `tx_busy` falling (seen in `WAIT_DONE`) to the next `req_ready` is 1 cycle (the `IDLE` decision).
- `tx_busy` already high in `ISSUE` is not sampled. Only `WAIT_BUSY` samples it, so a stale busy seen one cycle early is treated as the acknowledgement.
- Simultaneous `req_valid` rise and grant decision: sampled values at the edge are used; no combinational path from `req_valid` to `req_ready`.
- All outputs are registered.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants `ST_IDLE`, `ST_ISSUE`, `ST_WAIT_BUSY`, `ST_WAIT_DONE`;
  - `BYTE_W=8`.
- Sub-module `rr_pick`: combinational, `NUM_REQ`-wide rotating priority encoder.
  - Inputs: request vector, `ptr`.
  - Outputs: winner index, `any` flag.
- FSM, watchdog counter, and capture registers live in the top module.

## Test plan
- Single requester: `req_valid[2]=1`, `data=8'hA5`, `last=1`, with the transmitter model holding busy for 80 cycles -> `req_ready[2]` pulses once, `tx_start` follows 1 cycle later, `tx_data=8'hA5` throughout, `grant_id=2`.
- Round-robin: all 4 requesters valid with single-byte messages (`last=1`) -> grant order after reset is 0,1,2,3,0.
- Message lock: requester 1 sends 3 bytes with `last=0,0,1` while requester 0 is continuously valid -> three consecutive grants to 1, then requester 0.
- Locked stall: requester 3 sends `last=0`, then drops `valid` for 50 cycles while others are valid -> no `req_ready` pulses during that time, `locked=1`; when requester 3 resumes, it is granted.
- Watchdog: `tx_busy` tied to 0 -> `timeout_err` rises 16 cycles after entering `WAIT_BUSY`, state returns to `IDLE`, and the next requester is granted.
- Reset mid-frame: `reset=0` during `WAIT_DONE` -> all outputs are at reset values within the same cycle; after release, requester 0 has priority.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and byte width.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: search begins one slot past ptr_i and wraps around.
// Purely combinational, zero latency, no backpressure.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               any_o
);

  int   slot;
  logic found;

  always_comb begin
    win_idx_o = '0;
    found     = 1'b0;
    slot      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      slot = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[IDX_W'(slot)]) begin
        found     = 1'b1;
        win_idx_o = IDX_W'(slot);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter; accept-to-start is 1 cycle, all outputs registered.
// Requesters wait on req_ready while a frame is in flight; a locked message blocks everyone else.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int START_TIMEOUT = 16,
  localparam int IDX_W         = $clog2(NUM_REQ),
  localparam int CNT_W         = $clog2(START_TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      locked,
  output logic                      timeout_err
);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]    tx_data_q, tx_data_d;
  logic                 last_q, last_d;
  logic                 locked_q, locked_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   cand;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_any;

  // While a message is open only its owner may compete, so bytes never interleave.
  assign cand = locked_q ? (req_valid & (NUM_REQ'(1) << grant_q)) : req_valid;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i     (cand),
    .ptr_i     (ptr_q),
    .win_idx_o (win_idx),
    .any_o     (win_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    req_ready_d = '0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    last_d      = last_q;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          tx_data_d   = req_data[BYTE_W*int'(win_idx) +: BYTE_W];
          last_d      = req_last[win_idx];
          grant_d     = win_idx;
          req_ready_d = NUM_REQ'(1) << win_idx;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop the byte and release any message lock.
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          ptr_d    = grant_q;
          locked_d = ~last_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      grant_q     <= '0;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      last_q      <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      last_q      <= last_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign locked      = locked_q;
  assign timeout_err = timeout_q;

endmodule
